// File: rtl/decoder_pkg.sv
// Shared mode encodings, FSM state type and a generic one-hot helper for the
// sequential decoder family.
package decoder_pkg;

  localparam int MAX_SEL_W = 6;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_PULSE  = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2,
    ST_PULSE  = 2'd3
  } state_t;

  // Widest-case decode; callers keep only the low 2**SEL_W bits they need.
  function automatic logic [(1<<MAX_SEL_W)-1:0] onehot(input logic [MAX_SEL_W-1:0] sel,
                                                       input logic en);
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational SEL_W-to-2**SEL_W decoder with enable; at most one output bit
// is ever high.
module decoder_onehot
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  output logic [(1<<SEL_W)-1:0] y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < (1 << SEL_W); k++) begin
      y[k] = en && (sel == SEL_W'(k));
    end
  end

endmodule

// File: rtl/decoder_seq.sv
// Sequential one-hot decoder: direct decode, walking scan with dwell, and
// timed one-shot pulse, all with registered outputs.
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      A,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic                  start,
  output logic [(1<<SEL_W)-1:0] Y,
  output logic [SEL_W-1:0]      idx,
  output logic                  busy,
  output logic                  wrap
);

  localparam int OUT_N = 1 << SEL_W;

  state_t             state, state_n;
  logic [1:0]         mode_q;
  logic [SEL_W-1:0]   i, i_n;
  logic [DWELL_W-1:0] d, d_n;
  logic [SEL_W-1:0]   al, al_n;
  logic               armed, armed_n;
  logic               busy_n, wrap_n, show_n;
  logic [SEL_W-1:0]   idx_n;
  logic [OUT_N-1:0]   y_dec;

  // Y is always decoded from a single index, so it can never be multi-hot.
  decoder_onehot #(.SEL_W(SEL_W)) u_dec (
    .sel (idx_n),
    .en  (show_n),
    .y   (y_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      mode_q <= MODE_OFF;
      i      <= '0;
      d      <= '0;
      al     <= '0;
      armed  <= 1'b0;
      busy   <= 1'b0;
      wrap   <= 1'b0;
      idx    <= '0;
      Y      <= '0;
    end else begin
      state  <= state_n;
      mode_q <= mode;
      i      <= i_n;
      d      <= d_n;
      al     <= al_n;
      armed  <= armed_n;
      busy   <= busy_n;
      wrap   <= wrap_n;
      idx    <= idx_n;
      Y      <= y_dec;
    end
  end

  // A pulse is accepted one edge before it shows (armed), and a start seen on
  // the edge where the pulse ends re-arms immediately.
  always_comb begin
    state_n = state;
    i_n     = i;
    d_n     = d;
    al_n    = al;
    armed_n = 1'b0;
    busy_n  = 1'b0;
    wrap_n  = 1'b0;
    show_n  = 1'b0;
    idx_n   = '0;
    if (mode != mode_q) begin
      state_n = ST_IDLE;
      i_n     = '0;
      d_n     = '0;
      al_n    = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          i_n  = '0;
          d_n  = '0;
          al_n = '0;
          case (mode)
            MODE_DIRECT: begin
              state_n = ST_DIRECT;
              show_n  = en;
              if (en) idx_n = A;
            end
            MODE_SCAN: begin
              state_n = ST_SCAN;
              d_n     = dwell;
              show_n  = en;
            end
            MODE_PULSE: state_n = ST_PULSE;
            default:    state_n = ST_IDLE;
          endcase
        end
        ST_DIRECT: begin
          show_n = en;
          if (en) idx_n = A;
        end
        ST_SCAN: begin
          if (en) begin
            show_n = 1'b1;
            if (d == '0) begin
              i_n    = i + SEL_W'(1);
              d_n    = dwell;
              wrap_n = (i == '1);
            end else begin
              d_n = d - DWELL_W'(1);
            end
            idx_n = i_n;
          end
        end
        ST_PULSE: begin
          if (en) begin
            if (armed) begin
              busy_n = 1'b1;
              show_n = 1'b1;
              idx_n  = al;
            end else if (busy && (d != '0)) begin
              busy_n = 1'b1;
              show_n = 1'b1;
              idx_n  = al;
              d_n    = d - DWELL_W'(1);
            end else if (start) begin
              armed_n = 1'b1;
              al_n    = A;
              d_n     = dwell;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule
